// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The master (fetch) holds req with a stable addr until ack returns the word.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage with IF/ID register, skid buffer, delay-slot redirect and ack timeout.
// Optional macro IF_ALIGN_CHECK_EN adds the sticky adel_o misaligned-target flag.
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  if_fetch_if.master  imem,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        timeout_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        adel_o
`endif
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_RETRY
  } state_t;

  state_t            state_reg;
  logic [31:0]       pc_reg;
  logic [31:0]       target_reg;
  logic [31:0]       skid_reg;
  logic [31:0]       id_pc_reg;
  logic [31:0]       id_inst_reg;
  logic              branch_pending_reg;
  logic              timeout_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              req;
  logic              req_ack;
  logic              branch_take;
  logic              consume;
  logic [31:0]       target_aligned;
  logic [31:0]       pc_plus4;
  logic [31:0]       next_pc;

  assign req            = (state_reg == ST_REQ);
  assign req_ack        = req & imem.imem_ack;
  assign branch_take    = branch_flag_i & ~stall_i;
  assign target_aligned = branch_target_address_i & ~32'h0000_0003;
  assign pc_plus4       = pc_reg + 32'd4;

  // A fetch is consumed when its word moves into IF/ID; the pc then advances.
  assign consume = ~stall_i & ((req_ack) | (state_reg == ST_HOLD));

  // A branch arriving in the same cycle as the delay-slot hand-off redirects immediately.
  always_comb begin
    next_pc = pc_plus4;
    if (branch_take) begin
      next_pc = target_aligned;
    end else if (branch_pending_reg) begin
      next_pc = target_reg;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = req ? pc_reg : 32'h0000_0000;
  assign id_pc_o        = id_pc_reg;
  assign id_inst_o      = id_inst_reg;
  assign timeout_o      = timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      pc_reg             <= RESET_PC;
      target_reg         <= 32'h0000_0000;
      skid_reg           <= 32'h0000_0000;
      id_pc_reg          <= 32'h0000_0000;
      id_inst_reg        <= 32'h0000_0000;
      branch_pending_reg <= 1'b0;
      timeout_reg        <= 1'b0;
      cnt_reg            <= '0;
    end else begin
      timeout_reg <= 1'b0;

      if (branch_take && !consume) begin
        branch_pending_reg <= 1'b1;
        target_reg         <= target_aligned;
      end else if (consume) begin
        branch_pending_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_REQ;
          if (!stall_i) begin
            id_pc_reg   <= pc_reg;
            id_inst_reg <= 32'h0000_0000;
          end
        end

        ST_REQ: begin
          if (imem.imem_ack) begin
            cnt_reg <= '0;
            if (!stall_i) begin
              id_pc_reg   <= pc_reg;
              id_inst_reg <= imem.imem_rdata;
              pc_reg      <= next_pc;
            end else begin
              skid_reg  <= imem.imem_rdata;
              state_reg <= ST_HOLD;
            end
          end else begin
            if (cnt_reg == CNT_LAST) begin
              cnt_reg     <= '0;
              timeout_reg <= 1'b1;
              state_reg   <= ST_RETRY;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // Memory is slow: hand decode a NOP rather than repeating the last word.
            if (!stall_i) begin
              id_pc_reg   <= pc_reg;
              id_inst_reg <= 32'h0000_0000;
            end
          end
        end

        ST_HOLD: begin
          if (!stall_i) begin
            id_pc_reg   <= pc_reg;
            id_inst_reg <= skid_reg;
            pc_reg      <= next_pc;
            state_reg   <= ST_REQ;
          end
        end

        ST_RETRY: begin
          state_reg <= ST_REQ;
          if (!stall_i) begin
            id_pc_reg   <= pc_reg;
            id_inst_reg <= 32'h0000_0000;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic adel_reg;

  // Sticky until reset; the fetch itself proceeds at the masked address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adel_reg <= 1'b0;
    end else if (branch_take && (branch_target_address_i[1:0] != 2'b00)) begin
      adel_reg <= 1'b1;
    end
  end

  assign adel_o = adel_reg;
`endif

endmodule
